// File: rtl/mac_learning_table.sv
// Learning forwarding table: per request, scans all entries once, learns or
// refreshes the source MAC against its ingress port and returns the egress
// port mask for the destination MAC. Entries age out on a periodic tick.
//   clock, reset_n          : single clock, synchronous active-low reset
//   request_*               : valid/ready request (source MAC, destination MAC, ingress port)
//   age_tick                : aging strobe, latched until the next sweep starts
//   response_*              : valid/ready response (egress mask, destination hit)
//   entry_count             : number of valid entries
//   table_full_drop         : one-cycle pulse when a new source could not be learned
module mac_learning_table #(
  parameter int unsigned NUMBER_OF_PORTS = 4,
  parameter int unsigned TABLE_ENTRIES   = 8,
  parameter int unsigned AGE_WIDTH       = 4,
  parameter int unsigned AGE_LIMIT       = 10,
  localparam int unsigned PORT_WIDTH  = (NUMBER_OF_PORTS > 1) ? $clog2(NUMBER_OF_PORTS) : 1,
  localparam int unsigned COUNT_WIDTH = $clog2(TABLE_ENTRIES + 1)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       request_valid,
  output logic                       request_ready,
  input  logic [47:0]                request_source_mac,
  input  logic [47:0]                request_destination_mac,
  input  logic [PORT_WIDTH-1:0]      request_source_port,
  input  logic                       age_tick,
  output logic                       response_valid,
  input  logic                       response_ready,
  output logic [NUMBER_OF_PORTS-1:0] response_port_mask,
  output logic                       response_hit,
  output logic [COUNT_WIDTH-1:0]     entry_count,
  output logic                       table_full_drop
);

  localparam int unsigned INDEX_WIDTH = $clog2(TABLE_ENTRIES);
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(TABLE_ENTRIES - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SCAN      = 3'd1;
  localparam logic [2:0] ST_UPDATE    = 3'd2;
  localparam logic [2:0] ST_RESPOND   = 3'd3;
  localparam logic [2:0] ST_AGE_SWEEP = 3'd4;

  // Table storage
  logic                  tbl_valid [TABLE_ENTRIES];
  logic [47:0]           tbl_mac   [TABLE_ENTRIES];
  logic [PORT_WIDTH-1:0] tbl_port  [TABLE_ENTRIES];
  logic [AGE_WIDTH-1:0]  tbl_age   [TABLE_ENTRIES];

  // Control state
  logic [2:0]             state_q,       state_d;
  logic [INDEX_WIDTH-1:0] index_q,       index_d;
  logic                   age_pending_q, age_pending_d;
  logic [47:0]            src_mac_q,     src_mac_d;
  logic [47:0]            dst_mac_q,     dst_mac_d;
  logic [PORT_WIDTH-1:0]  src_port_q,    src_port_d;
  logic                   src_hit_q,     src_hit_d;
  logic [INDEX_WIDTH-1:0] src_idx_q,     src_idx_d;
  logic                   dst_hit_q,     dst_hit_d;
  logic [PORT_WIDTH-1:0]  dst_port_q,    dst_port_d;
  logic                   free_found_q,  free_found_d;
  logic [INDEX_WIDTH-1:0] free_idx_q,    free_idx_d;

  logic                       ready_d;
  logic                       resp_valid_d;
  logic [NUMBER_OF_PORTS-1:0] mask_d;
  logic                       hit_d;
  logic [COUNT_WIDTH-1:0]     count_d;
  logic                       drop_d;

  // Table write controls
  logic                   wr_en;
  logic [INDEX_WIDTH-1:0] wr_idx;
  logic                   inval_en;
  logic                   age_inc_en;

  // One-hot of a port index; indices beyond the port count produce no bit
  function automatic logic [NUMBER_OF_PORTS-1:0] port_onehot(input logic [PORT_WIDTH-1:0] p);
    logic [NUMBER_OF_PORTS-1:0] r;
    for (int i = 0; i < NUMBER_OF_PORTS; i++) r[i] = (32'(p) == 32'(i));
    return r;
  endfunction

  // Next-state and output logic
  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    age_pending_d = age_pending_q;
    src_mac_d     = src_mac_q;
    dst_mac_d     = dst_mac_q;
    src_port_d    = src_port_q;
    src_hit_d     = src_hit_q;
    src_idx_d     = src_idx_q;
    dst_hit_d     = dst_hit_q;
    dst_port_d    = dst_port_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    resp_valid_d  = response_valid;
    mask_d        = response_port_mask;
    hit_d         = response_hit;
    count_d       = entry_count;
    drop_d        = 1'b0;
    wr_en         = 1'b0;
    wr_idx        = src_idx_q;
    inval_en      = 1'b0;
    age_inc_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (age_pending_q) begin
          state_d = ST_AGE_SWEEP;
          index_d = '0;
        end else if (request_valid && request_ready) begin
          src_mac_d    = request_source_mac;
          dst_mac_d    = request_destination_mac;
          src_port_d   = request_source_port;
          src_hit_d    = 1'b0;
          dst_hit_d    = 1'b0;
          free_found_d = 1'b0;
          index_d      = '0;
          state_d      = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (tbl_valid[index_q]) begin
          if (tbl_mac[index_q] == src_mac_q) begin
            src_hit_d = 1'b1;
            src_idx_d = index_q;
          end
          if (tbl_mac[index_q] == dst_mac_q) begin
            dst_hit_d  = 1'b1;
            dst_port_d = tbl_port[index_q];
          end
        end else if (!free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = index_q;
        end
        if (index_q == LAST_INDEX) state_d = ST_UPDATE;
        else                       index_d = index_q + INDEX_WIDTH'(1);
      end

      ST_UPDATE: begin
        // Multicast sources (I/G bit set) are never learned
        if (!src_mac_q[40]) begin
          if (src_hit_q) begin
            wr_en  = 1'b1;
            wr_idx = src_idx_q;
          end else if (free_found_q) begin
            wr_en   = 1'b1;
            wr_idx  = free_idx_q;
            count_d = entry_count + COUNT_WIDTH'(1);
          end else begin
            drop_d = 1'b1;
          end
        end
        // Mask reflects the table as it was before this request's learn
        if (dst_mac_q[40] || !dst_hit_q) begin
          mask_d = ~port_onehot(src_port_q);
          hit_d  = 1'b0;
        end else if (dst_port_q == src_port_q) begin
          mask_d = '0;
          hit_d  = 1'b1;
        end else begin
          mask_d = port_onehot(dst_port_q);
          hit_d  = 1'b1;
        end
        resp_valid_d = 1'b1;
        state_d      = ST_RESPOND;
      end

      ST_RESPOND: begin
        if (response_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end

      ST_AGE_SWEEP: begin
        if (tbl_valid[index_q]) begin
          if (tbl_age[index_q] == AGE_WIDTH'(AGE_LIMIT)) begin
            inval_en = 1'b1;
            count_d  = entry_count - COUNT_WIDTH'(1);
          end else begin
            age_inc_en = 1'b1;
          end
        end
        if (index_q == LAST_INDEX) state_d = ST_IDLE;
        else                       index_d = index_q + INDEX_WIDTH'(1);
      end

      default: state_d = ST_IDLE;
    endcase

    // Starting a sweep consumes the pending tick; a tick in that same cycle is
    // absorbed, any later tick re-arms the flag for a follow-up sweep
    if (state_q == ST_IDLE && age_pending_q) age_pending_d = 1'b0;
    else if (age_tick)                       age_pending_d = 1'b1;

    ready_d = (state_d == ST_IDLE) && !age_pending_d;
  end

  // Control and output registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q            <= ST_IDLE;
      index_q            <= '0;
      age_pending_q      <= 1'b0;
      src_mac_q          <= '0;
      dst_mac_q          <= '0;
      src_port_q         <= '0;
      src_hit_q          <= 1'b0;
      src_idx_q          <= '0;
      dst_hit_q          <= 1'b0;
      dst_port_q         <= '0;
      free_found_q       <= 1'b0;
      free_idx_q         <= '0;
      request_ready      <= 1'b0;
      response_valid     <= 1'b0;
      response_port_mask <= '0;
      response_hit       <= 1'b0;
      entry_count        <= '0;
      table_full_drop    <= 1'b0;
    end else begin
      state_q            <= state_d;
      index_q            <= index_d;
      age_pending_q      <= age_pending_d;
      src_mac_q          <= src_mac_d;
      dst_mac_q          <= dst_mac_d;
      src_port_q         <= src_port_d;
      src_hit_q          <= src_hit_d;
      src_idx_q          <= src_idx_d;
      dst_hit_q          <= dst_hit_d;
      dst_port_q         <= dst_port_d;
      free_found_q       <= free_found_d;
      free_idx_q         <= free_idx_d;
      request_ready      <= ready_d;
      response_valid     <= resp_valid_d;
      response_port_mask <= mask_d;
      response_hit       <= hit_d;
      entry_count        <= count_d;
      table_full_drop    <= drop_d;
    end
  end

  // Table storage updates
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < TABLE_ENTRIES; i++) begin
        tbl_valid[i] <= 1'b0;
        tbl_mac[i]   <= '0;
        tbl_port[i]  <= '0;
        tbl_age[i]   <= '0;
      end
    end else begin
      if (wr_en) begin
        tbl_valid[wr_idx] <= 1'b1;
        tbl_mac[wr_idx]   <= src_mac_q;
        tbl_port[wr_idx]  <= src_port_q;
        tbl_age[wr_idx]   <= '0;
      end
      if (inval_en)   tbl_valid[index_q] <= 1'b0;
      if (age_inc_en) tbl_age[index_q]   <= tbl_age[index_q] + AGE_WIDTH'(1);
    end
  end

endmodule
